aer_rx_12: RTL

AER_RX_12 -- requirements
Module: aer_rx_12

---
 rtl/aer_rx_12.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/aer_rx_12.sv
// Receiver for a 12-input AER arbiter tree: four-phase handshake with the tree root,
// grant decode to a taxel index, timestamping and a small event FIFO.
module aer_rx_12 #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TS_W       = 16,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ro,
  output logic            n_ri,
  input  logic [11:0]     n_lno,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [3:0]      ev_addr,
  output logic [TS_W-1:0] ev_time,
  output logic            err_multi,
  output logic            err_timeout
);

  localparam int unsigned AW   = (FIFO_DEPTH < 2) ? 1 : $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StAck, StWaitRoLow, StRelease} state_e;

  state_e            r_state, w_state_d;
  logic              r_ro_m, r_ro_s;
  logic [11:0]       r_g_m, r_g_s, r_g_prev;
  logic [TS_W-1:0]   r_ts, r_ts_lat;
  logic              r_n_ri, w_n_ri_d;
  logic [CW-1:0]     r_wait;
  logic              r_err_multi, r_err_timeout;
  logic [3:0]        r_mem_addr [FIFO_DEPTH];
  logic [TS_W-1:0]   r_mem_time [FIFO_DEPTH];
  logic [AW-1:0]     r_wp, r_rp;
  logic [CNTW-1:0]   r_cnt;

  logic        w_full, w_pop, w_push, w_latch, w_set_multi, w_set_tmo;
  logic        w_stable, w_onehot, w_tmo;
  logic [11:0] w_inv;
  logic [3:0]  w_idx;

  assign w_full   = (r_cnt == CNTW'(FIFO_DEPTH));
  assign ev_valid = (r_cnt != '0);
  assign w_pop    = ev_valid & ev_ready;
  assign w_inv    = ~r_g_s;
  // A grant counts only once the synchronized value has been identical for two cycles.
  assign w_stable = (r_g_s != 12'hFFF) && (r_g_s == r_g_prev);
  assign w_onehot = ((w_inv & (w_inv - 12'd1)) == 12'd0);
  assign w_tmo    = (r_wait == CW'(TIMEOUT));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (w_inv[i]) w_idx = 4'(i);
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_n_ri_d    = r_n_ri;
    w_push      = 1'b0;
    w_latch     = 1'b0;
    w_set_multi = 1'b0;
    w_set_tmo   = 1'b0;
    unique case (r_state)
      StIdle: begin
        // Only one handshake is ever in flight, so a free slot here stays reserved for it.
        if (r_ro_s && !w_full) begin
          w_state_d = StAck;
          w_n_ri_d  = 1'b0;
          w_latch   = 1'b1;
        end
      end
      StAck: begin
        if (w_stable) begin
          w_state_d = StWaitRoLow;
          if (w_onehot) w_push      = 1'b1;
          else          w_set_multi = 1'b1;
        end else if (w_tmo) begin
          w_state_d = StRelease;
          w_n_ri_d  = 1'b1;
          w_set_tmo = 1'b1;
        end
      end
      StWaitRoLow: begin
        if (!r_ro_s) begin
          w_state_d = StRelease;
          w_n_ri_d  = 1'b1;
        end else if (w_tmo) begin
          w_state_d = StRelease;
          w_n_ri_d  = 1'b1;
          w_set_tmo = 1'b1;
        end
      end
      StRelease: begin
        if (r_g_s == 12'hFFF) begin
          w_state_d = StIdle;
        end else if (w_tmo) begin
          w_state_d = StIdle;
          w_set_tmo = 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_ro_m        <= 1'b0;
      r_ro_s        <= 1'b0;
      r_g_m         <= 12'hFFF;
      r_g_s         <= 12'hFFF;
      r_g_prev      <= 12'hFFF;
      r_ts          <= '0;
      r_ts_lat      <= '0;
      r_n_ri        <= 1'b1;
      r_wait        <= '0;
      r_err_multi   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_wp          <= '0;
      r_rp          <= '0;
      r_cnt         <= '0;
    end else begin
      r_state  <= w_state_d;
      r_ro_m   <= ro;
      r_ro_s   <= r_ro_m;
      r_g_m    <= n_lno;
      r_g_s    <= r_g_m;
      r_g_prev <= r_g_s;
      r_ts     <= r_ts + TS_W'(1);
      r_n_ri   <= w_n_ri_d;
      if (w_latch) r_ts_lat <= r_ts;
      if ((w_state_d != r_state) || (r_state == StIdle)) r_wait <= '0;
      else                                                 r_wait <= r_wait + CW'(1);
      if (w_set_multi) r_err_multi   <= 1'b1;
      if (w_set_tmo)   r_err_timeout <= 1'b1;
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNTW'(1);
        2'b01:   r_cnt <= r_cnt - CNTW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wp] <= w_idx;
      r_mem_time[r_wp] <= r_ts_lat;
    end
  end

  assign n_ri        = r_n_ri;
  assign ev_addr     = ev_valid ? r_mem_addr[r_rp] : '0;
  assign ev_time     = ev_valid ? r_mem_time[r_rp] : '0;
  assign err_multi   = r_err_multi;
  assign err_timeout = r_err_timeout;

endmodule
